// File: rtl/gbar_unit.sv
// gbar_unit -- responder end of the global barrier protocol.
//
// Shared by every core in the cluster. Each core posts one arrival per
// barrier epoch, carrying the barrier id, the participant count minus one
// and its own core id. Arrivals are counted per barrier id. The arrival that
// completes the set clears that barrier's state and produces a registered,
// one-cycle release broadcast carrying the id.
//
// Ports
//   clk           clock
//   reset_n       asynchronous active-low reset
//   req_valid     arrival request valid
//   req_id        barrier id of the arrival
//   req_size_m1   participating cores minus one
//   req_core_id   arriving core
//   req_ready     always 1: one arrival is accepted every cycle
//   rsp_valid     one-cycle release pulse
//   rsp_id        id being released; holds its last value otherwise
//   dup_err       one-cycle pulse after an arrival from an already-recorded core
//   pending_mask  bit b set while barrier b has recorded arrivals
module gbar_unit #(
  parameter  int NUM_BARRIERS = 8,
  parameter  int NUM_CORES    = 4,
  localparam int NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
  localparam int NC_W         = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  input  logic [NB_BITS-1:0]      req_id,
  input  logic [NC_W-1:0]         req_size_m1,
  input  logic [NC_W-1:0]         req_core_id,
  output logic                    req_ready,
  output logic                    rsp_valid,
  output logic [NB_BITS-1:0]      rsp_id,
  output logic                    dup_err,
  output logic [NUM_BARRIERS-1:0] pending_mask
);

  logic [NUM_BARRIERS-1:0][NC_W-1:0]      count_q, count_d;
  logic [NUM_BARRIERS-1:0][NUM_CORES-1:0] mask_q, mask_d;
  logic                                   rsp_valid_q, rsp_valid_d;
  logic [NB_BITS-1:0]                     rsp_id_q, rsp_id_d;
  logic                                   dup_err_q, dup_err_d;
  logic [NUM_CORES-1:0]                   core_onehot;

  // Core ids beyond NUM_CORES shift out to an all-zero vector, so they can
  // never index past the arrival mask.
  assign core_onehot = NUM_CORES'(1) << req_core_id;

  // The id is decoded by comparison rather than used as an index so an
  // out-of-range id (non power-of-two NUM_BARRIERS) simply matches nothing.
  always_comb begin
    count_d     = count_q;
    mask_d      = mask_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    dup_err_d   = 1'b0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      if (req_valid && (req_id == NB_BITS'(b))) begin
        if (|(mask_q[b] & core_onehot)) begin
          dup_err_d = 1'b1;
        end else if (count_q[b] == req_size_m1) begin
          // Last participant: clear the epoch so an arrival in the release
          // cycle already starts the next one from zero.
          count_d[b]  = '0;
          mask_d[b]   = '0;
          rsp_valid_d = 1'b1;
          rsp_id_d    = NB_BITS'(b);
        end else begin
          count_d[b] = count_q[b] + NC_W'(1);
          mask_d[b]  = mask_q[b] | core_onehot;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= '0;
      mask_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      dup_err_q   <= 1'b0;
    end else begin
      count_q     <= count_d;
      mask_q      <= mask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      dup_err_q   <= dup_err_d;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      pending_mask[b] = |mask_q[b];
    end
  end

  assign req_ready = 1'b1;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign dup_err   = dup_err_q;

endmodule

// File: tb/tb_gbar_unit.sv
module tb_gbar_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic [2:0] req_id;
  logic [1:0] req_size_m1;
  logic [1:0] req_core_id;
  logic       req_ready;
  logic       rsp_valid;
  logic [2:0] rsp_id;
  logic       dup_err;
  logic [7:0] pending_mask;

  int errors = 0;
  int checks = 0;

  // Reference model: the list of cores that have arrived in the current
  // epoch of each barrier, plus the last released id.
  int members [8][$];
  int last_rid = 0;
  int sz_of [8];

  gbar_unit #(.NUM_BARRIERS(8), .NUM_CORES(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_id       (req_id),
    .req_size_m1  (req_size_m1),
    .req_core_id  (req_core_id),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .dup_err      (dup_err),
    .pending_mask (pending_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int b = 0; b < 8; b++) members[b].delete();
    last_rid = 0;
  endtask

  function automatic logic [7:0] model_pending();
    logic [7:0] p;
    for (int b = 0; b < 8; b++) p[b] = (members[b].size() > 0);
    return p;
  endfunction

  // One clock: present an arrival (or idle), let the edge take it, then
  // compare the registered outputs against the model's prediction.
  task automatic step(input bit v, input int id, input int sz, input int core);
    bit exp_rv, exp_dup, found;
    req_valid   = v;
    req_id      = 3'(id);
    req_size_m1 = 2'(sz);
    req_core_id = 2'(core);
    @(posedge clk);
    #1;
    exp_rv  = 1'b0;
    exp_dup = 1'b0;
    if (v) begin
      found = 1'b0;
      for (int i = 0; i < members[id].size(); i++)
        if (members[id][i] == core) found = 1'b1;
      if (found) begin
        exp_dup = 1'b1;
      end else if (members[id].size() == sz) begin
        members[id].delete();
        exp_rv   = 1'b1;
        last_rid = id;
      end else begin
        members[id].push_back(core);
      end
    end
    req_valid = 1'b0;
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    chk("rsp_id", 32'(rsp_id), 32'(last_rid));
    chk("dup_err", 32'(dup_err), 32'(exp_dup));
    chk("pending_mask", 32'(pending_mask), 32'(model_pending()));
    chk("req_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    model_clear();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_dup_err", 32'(dup_err), 32'd0);
    chk("rst_pending", 32'(pending_mask), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n     = 1'b0;
    req_valid   = 1'b0;
    req_id      = '0;
    req_size_m1 = '0;
    req_core_id = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Four-core barrier on id 3.
    for (int c = 0; c < 4; c++) step(1, 3, 3, c);
    step(0, 0, 0, 0);
    // Single-core barrier releases immediately.
    step(1, 5, 0, 2);
    step(0, 0, 0, 0);
    // Interleaved two-core epochs on ids 1 and 2.
    step(1, 1, 1, 0);
    step(1, 2, 1, 0);
    step(1, 2, 1, 1);
    step(1, 1, 1, 1);
    step(0, 0, 0, 0);
    // Duplicate arrival on id 4.
    step(1, 4, 1, 0);
    step(1, 4, 1, 0);
    step(1, 4, 1, 1);
    step(0, 0, 0, 0);
    // Re-arm in the release cycle on id 0.
    step(1, 0, 1, 0);
    step(1, 0, 1, 1);
    step(1, 0, 1, 0);
    step(0, 0, 0, 0);
    step(1, 0, 1, 1);
    step(0, 0, 0, 0);
    // Reset mid-epoch discards partial arrivals on id 6.
    for (int c = 0; c < 3; c++) step(1, 6, 3, c);
    do_reset();
    step(1, 6, 3, 3);
    for (int c = 0; c < 3; c++) step(1, 6, 3, c);
    step(0, 0, 0, 0);

    // Random traffic with a fixed participant count per barrier.
    do_reset();
    for (int b = 0; b < 8; b++) sz_of[b] = $urandom_range(0, 3);
    for (int n = 0; n < 400; n++) begin
      int rid;
      rid = $urandom_range(0, 7);
      step(($urandom_range(0, 9) < 8), rid, sz_of[rid], $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
